// File: rtl/multi_sync_pulse.sv
// multi_sync_pulse: per-channel synchroniser, persistence filter and edge-event detector
// Rev 1.0 - initial release
`default_nettype none

module multi_sync_pulse #(
  parameter int WIDTH         = 1,
  parameter int STAGES        = 2,
  parameter int FILTER_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] pending,
  output logic             any_pending
);

  localparam int              CNT_W   = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("multi_sync_pulse: STAGES must be at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] synced;

  // Pure wiring between chain flops so every stage gets a full cycle to resolve.
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign synced = sync_q[STAGES-1];

  always_comb begin
    q_d = q_q;
    p_d = '0;
    for (int ch = 0; ch < WIDTH; ch++) begin
      cnt_d[ch] = '0;
      if (synced[ch] != q_q[ch]) begin
        if (cnt_q[ch] == CNT_MAX) begin
          q_d[ch] = synced[ch];
          p_d[ch] = synced[ch] ? rise_en[ch] : fall_en[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
    // A new event beats a simultaneous clear so nothing is lost.
    pending_d = p_d | (pending_q & ~clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
      for (int ch = 0; ch < WIDTH; ch++) begin
        cnt_q[ch] <= '0;
      end
      q_q       <= '0;
      p_q       <= '0;
      pending_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      for (int ch = 0; ch < WIDTH; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
      q_q       <= q_d;
      p_q       <= p_d;
      pending_q <= pending_d;
    end
  end

  assign q           = q_q;
  assign p           = p_q;
  assign pending     = pending_q;
  assign any_pending = |pending_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_sync_pulse.sv
// tb_multi_sync_pulse: three parameterisations driven in parallel, checked against a window-based model
// Rev 1.0 - initial release
`default_nettype none

module tb_multi_sync_pulse;

  localparam int W = 4;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] d, rise_en, fall_en, clr;
  logic [W-1:0] q_o    [N];
  logic [W-1:0] p_o    [N];
  logic [W-1:0] pend_o [N];
  logic         anyp_o [N];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multi_sync_pulse #(.WIDTH(W), .STAGES(2), .FILTER_CYCLES(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .d(d), .rise_en(rise_en), .fall_en(fall_en), .clr(clr),
    .q(q_o[0]), .p(p_o[0]), .pending(pend_o[0]), .any_pending(anyp_o[0]));

  multi_sync_pulse #(.WIDTH(W), .STAGES(3), .FILTER_CYCLES(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .d(d), .rise_en(rise_en), .fall_en(fall_en), .clr(clr),
    .q(q_o[1]), .p(p_o[1]), .pending(pend_o[1]), .any_pending(anyp_o[1]));

  multi_sync_pulse #(.WIDTH(W), .STAGES(2), .FILTER_CYCLES(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .d(d), .rise_en(rise_en), .fall_en(fall_en), .clr(clr),
    .q(q_o[2]), .p(p_o[2]), .pending(pend_o[2]), .any_pending(anyp_o[2]));

  function automatic int stages_of(int i);
    case (i)
      0:       return 2;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int filt_of(int i);
    case (i)
      0:       return 0;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  // Model: d history per clock edge; an output level flips once the last
  // FILTER_CYCLES+1 synchronised samples (d delayed by STAGES edges) all disagree with it.
  logic [W-1:0] dh [$];
  logic [W-1:0] mq    [N];
  logic [W-1:0] mp    [N];
  logic [W-1:0] mpend [N];

  task automatic model_reset();
    dh.delete();
    for (int k = 0; k < 16; k++) dh.push_back('0);
    for (int i = 0; i < N; i++) begin
      mq[i] = '0; mp[i] = '0; mpend[i] = '0;
    end
  endtask

  task automatic model_step();
    logic all_diff;
    logic newp;
    dh.push_back(d);
    if (dh.size() > 64) void'(dh.pop_front());
    for (int i = 0; i < N; i++) begin
      for (int ch = 0; ch < W; ch++) begin
        all_diff = 1'b1;
        for (int m = stages_of(i); m <= stages_of(i) + filt_of(i); m++) begin
          if (dh[dh.size() - 1 - m][ch] == mq[i][ch]) all_diff = 1'b0;
        end
        newp = 1'b0;
        if (all_diff) begin
          mq[i][ch] = ~mq[i][ch];
          newp = mq[i][ch] ? rise_en[ch] : fall_en[ch];
        end
        mp[i][ch]    = newp;
        mpend[i][ch] = newp | (mpend[i][ch] & ~clr[ch]);
      end
    end
  endtask

  task automatic chk(input string tag, input int i, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s[%0d] at %0t: observed=%h expected=%h", tag, i, $time, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk("q", i, q_o[i], mq[i]);
      chk("p", i, p_o[i], mp[i]);
      chk("pending", i, pend_o[i], mpend[i]);
      chk("any_pending", i, {3'b000, anyp_o[i]}, {3'b000, |mpend[i]});
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Called at a negedge; with mid_cycle the reset drops between edges and
  // outputs are checked before any further clock edge.
  task automatic do_reset(input bit mid_cycle);
    if (mid_cycle) begin
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
    end else begin
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      model_reset();
    end
    check_all();
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    d       = '0;
    rise_en = '1;
    fall_en = '1;
    clr     = '0;
    model_reset();
    @(negedge clk);
    do_reset(1'b0);

    // Rising edge on every channel, pending held, then cleared.
    d = '1;
    repeat (10) cycle();
    clr = '1; cycle();
    clr = '0; cycle();

    // Falling edge, then 3-wide and 4-wide pulses against the filtered instance.
    d = '0;
    repeat (12) cycle();
    clr = '1; cycle();
    clr = '0;
    d = '1; repeat (3) cycle();
    d = '0; repeat (10) cycle();
    d = '1; repeat (4) cycle();
    d = '0; repeat (12) cycle();

    // Fall-only events on channels 0 and 2.
    rise_en = '0;
    fall_en = 4'b0101;
    clr = '1; d = '1; repeat (12) cycle();
    clr = '0; d = '0; repeat (12) cycle();

    // Clear held high across a new event: the event still lands in pending.
    rise_en = '1;
    fall_en = '1;
    clr = '1; d = '1; repeat (12) cycle();
    clr = '0; cycle();
    clr = 4'b0001; cycle();
    clr = '0; cycle();

    // Toggle every cycle: filtered instances must hold q.
    for (int k = 0; k < 100; k++) begin
      d = ~d;
      cycle();
    end
    clr = '1; cycle();
    clr = '0;

    // Randomised levels, enables and clears.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) d = W'($urandom);
      if ($urandom_range(0, 19) == 0) rise_en = W'($urandom);
      if ($urandom_range(0, 19) == 0) fall_en = W'($urandom);
      clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      cycle();
    end

    // Reset mid-filter with pending set, then a rise from d held high.
    rise_en = '1;
    fall_en = '1;
    clr     = '0;
    d = '1; repeat (12) cycle();
    d = '0; repeat (5) cycle();
    d = '1;
    do_reset(1'b1);
    repeat (12) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
